// File: rtl/call_return_sequencer.sv
// call_return_sequencer: turns one-cycle CALL/RET opcodes from the decoder
// into timed instruction-stack strobes and PC-load commands. It tracks stack
// occupancy, stalls fetch while a sequence is in flight, and traps overflow,
// underflow and simultaneous CALL/RET requests into a sticky FAULT state.
module call_return_sequencer #(
  parameter int addr_width = 4,
  parameter int data_width = 8
) (
  input  logic                  local_clk,
  input  logic                  rst,
  input  logic                  op_call,
  input  logic                  op_rtrn,
  input  logic [data_width-1:0] i_PC,
  input  logic [data_width-1:0] i_target,
  input  logic [data_width-1:0] i_stack_top,
  input  logic                  err_clr,
  output logic                  stack_call,
  output logic                  stack_rtrn,
  output logic [data_width-1:0] stack_pc,
  output logic [data_width-1:0] pc_next,
  output logic                  pc_load,
  output logic                  stall,
  output logic [addr_width:0]   depth,
  output logic                  err_ovf,
  output logic                  err_udf,
  output logic                  err_ill
);

  // Occupancy at which the stack is full (2**addr_width entries).
  localparam logic [addr_width:0] depth_full = {1'b1, {addr_width{1'b0}}};
  localparam logic [addr_width:0] depth_one  = (addr_width + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALL,
    S_RET_POP,
    S_RET_LOAD,
    S_FAULT
  } state_t;

  state_t state;
  state_t state_next;

  logic                  accept_call;
  logic                  set_ill;
  logic                  set_ovf;
  logic                  set_udf;
  logic [data_width-1:0] stack_pc_q;
  logic [data_width-1:0] pc_next_q;

  // State register; reset aborts any in-flight sequence immediately.
  always_ff @(posedge local_clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; opcodes are only looked at while idle, with the
  // illegal/overflow/underflow traps taking priority over acceptance.
  always_comb begin
    state_next  = state;
    accept_call = 1'b0;
    set_ill     = 1'b0;
    set_ovf     = 1'b0;
    set_udf     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (op_call && op_rtrn) begin
          state_next = S_FAULT;
          set_ill    = 1'b1;
        end else if (op_call && (depth == depth_full)) begin
          state_next = S_FAULT;
          set_ovf    = 1'b1;
        end else if (op_rtrn && (depth == '0)) begin
          state_next = S_FAULT;
          set_udf    = 1'b1;
        end else if (op_call) begin
          state_next  = S_CALL;
          accept_call = 1'b1;
        end else if (op_rtrn) begin
          state_next = S_RET_POP;
        end
      end
      S_CALL:     state_next = S_IDLE;
      S_RET_POP:  state_next = S_RET_LOAD;
      S_RET_LOAD: state_next = S_IDLE;
      S_FAULT: begin
        if (err_clr) begin
          state_next = S_IDLE;
        end
      end
      default:    state_next = S_IDLE;
    endcase
  end

  // Output decode from state only, so no opcode reaches a strobe combinationally.
  // The return address is forwarded straight from the stack read port during
  // RET_LOAD because the stack only presents it after the pop edge.
  always_comb begin
    stack_call = (state == S_CALL);
    stack_rtrn = (state == S_RET_POP);
    pc_load    = (state == S_CALL) || (state == S_RET_LOAD);
    stall      = (state != S_IDLE);
    stack_pc   = stack_pc_q;
    pc_next    = (state == S_RET_LOAD) ? i_stack_top : pc_next_q;
  end

  // Capture the return PC and call destination on the accepting edge.
  always_ff @(posedge local_clk or posedge rst) begin
    if (rst) begin
      stack_pc_q <= '0;
      pc_next_q  <= '0;
    end else if (accept_call) begin
      stack_pc_q <= i_PC;
      pc_next_q  <= i_target;
    end
  end

  // Mirror of the stack pointer: it moves on the same edges the stack does.
  always_ff @(posedge local_clk or posedge rst) begin
    if (rst) begin
      depth <= '0;
    end else if (state == S_CALL) begin
      depth <= depth + depth_one;
    end else if (state == S_RET_POP) begin
      depth <= depth - depth_one;
    end
  end

  // Sticky error flags, cleared only when software acknowledges the fault.
  always_ff @(posedge local_clk or posedge rst) begin
    if (rst) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
      err_ill <= 1'b0;
    end else if ((state == S_FAULT) && err_clr) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
      err_ill <= 1'b0;
    end else begin
      err_ovf <= err_ovf | set_ovf;
      err_udf <= err_udf | set_udf;
      err_ill <= err_ill | set_ill;
    end
  end

endmodule
